// File: rtl/wb_interconnect_nslave_pkg.sv
// Shared slave map for the Wishbone 1-master / N-slave interconnect:
// slave indices and the default SoC base/mask tables.
package wb_interconnect_nslave_pkg;

  localparam int SLV_SRAM = 0;
  localparam int SLV_LED  = 1;
  localparam int SLV_UART = 2;
  localparam int SLV_CDT  = 3;

  // Slave 0 occupies the least significant word.
  localparam logic [127:0] DEF_SLAVE_BASE =
    {32'h8000_0010, 32'h8000_0008, 32'h8000_0000, 32'h0000_0000};
  localparam logic [127:0] DEF_SLAVE_MASK =
    {32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'hFFFE_0000};

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// Address decoder: per-slave base/mask match with lowest-index priority.
module wb_addr_decode #(
  parameter int              NS   = 4,
  parameter int              AW   = 32,
  parameter int              IW   = 2,
  parameter logic [NS*AW-1:0] BASE = '0,
  parameter logic [NS*AW-1:0] MASK = '0
) (
  input  logic [AW-1:0] addr,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [NS-1:0] match;

  always_comb begin
    match = '0;
    for (int k = 0; k < NS; k++)
      match[k] = ((addr & MASK[k*AW +: AW]) == BASE[k*AW +: AW]);
  end

  // Walk downwards so the lowest matching index is the one left in idx.
  always_comb begin
    idx = '0;
    for (int k = NS - 1; k >= 0; k--)
      if (match[k]) idx = IW'(k);
  end

  assign valid = |match;

endmodule

// File: rtl/wb_interconnect_nslave.sv
// Wishbone B4 pipelined 1-master / NS-slave interconnect with in-order
// completion, unmapped/timeout bus errors and faulting-address capture.
module wb_interconnect_nslave
  import wb_interconnect_nslave_pkg::*;
#(
  parameter int               NS         = 4,
  parameter int               AW         = 32,
  parameter int               DW         = 32,
  parameter logic [NS*AW-1:0] SLAVE_BASE = DEF_SLAVE_BASE,
  parameter logic [NS*AW-1:0] SLAVE_MASK = DEF_SLAVE_MASK,
  parameter int               TIMEOUT    = 255,
  parameter int               MAXOUT     = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [AW-1:0]    i_wb_addr,
  input  logic [DW-1:0]    i_wb_data,
  input  logic [DW/8-1:0]  i_wb_sel,
  input  logic             i_wb_we,
  input  logic             i_wb_cyc,
  input  logic             i_wb_stb,
  output logic             o_wb_ack,
  output logic [DW-1:0]    o_wb_data,
  output logic             o_wb_stall,
  output logic             o_wb_err,
  output logic [AW-1:0]    o_wb_err_address,
  output logic [NS-1:0]    o_s_cyc,
  output logic [NS-1:0]    o_s_stb,
  output logic [AW-1:0]    o_s_addr,
  output logic [DW-1:0]    o_s_data,
  output logic [DW/8-1:0]  o_s_sel,
  output logic             o_s_we,
  input  logic [NS-1:0]    i_s_ack,
  input  logic [NS*DW-1:0] i_s_data,
  input  logic [NS-1:0]    i_s_stall,
  input  logic [NS-1:0]    i_s_err
);

  localparam int IW = idx_w(NS);
  localparam int NW = $clog2(MAXOUT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [IW-1:0] dec_idx;
  logic          dec_valid;
  logic [IW-1:0] owner;
  logic [NW-1:0] nout;
  logic [TW-1:0] timer;
  logic [AW-1:0] last_addr;

  logic busy, blocked, accept, map_acc, unm_acc;
  logic resp_ack, slv_err, tmo, any_err, evt;

  wb_addr_decode #(
    .NS(NS), .AW(AW), .IW(IW), .BASE(SLAVE_BASE), .MASK(SLAVE_MASK)
  ) u_dec (
    .addr  (i_wb_addr),
    .idx   (dec_idx),
    .valid (dec_valid)
  );

  assign busy    = (nout != '0);
  // Ownership/capacity stall gates the slave strobe; a slave's own stall does not.
  assign blocked = (busy && (!dec_valid || dec_idx != owner)) || (nout == NW'(MAXOUT));
  assign o_wb_stall = i_wb_stb & (blocked | (dec_valid & i_s_stall[dec_idx]));
  assign accept  = i_wb_cyc & i_wb_stb & ~o_wb_stall;
  assign map_acc = accept & dec_valid;
  assign unm_acc = accept & ~dec_valid;

  assign resp_ack = i_wb_cyc & busy & i_s_ack[owner];
  assign slv_err  = i_wb_cyc & busy & i_s_err[owner];
  assign evt      = resp_ack | slv_err | accept;
  assign tmo      = i_wb_cyc & busy & ~evt & (timer == TW'(TIMEOUT - 1));
  assign any_err  = slv_err | unm_acc | tmo;

  always_comb begin
    o_s_stb = '0;
    o_s_cyc = '0;
    for (int k = 0; k < NS; k++) begin
      o_s_stb[k] = i_wb_cyc & i_wb_stb & dec_valid & (dec_idx == IW'(k)) & ~blocked;
      o_s_cyc[k] = i_wb_cyc & ((busy & (owner == IW'(k))) | o_s_stb[k]);
    end
  end

  assign o_s_addr = i_wb_addr;
  assign o_s_data = i_wb_data;
  assign o_s_sel  = i_wb_sel;
  assign o_s_we   = i_wb_we;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_wb_ack         <= 1'b0;
      o_wb_data        <= '0;
      o_wb_err         <= 1'b0;
      o_wb_err_address <= '0;
      owner            <= '0;
      nout             <= '0;
      timer            <= '0;
      last_addr        <= '0;
    end else begin
      o_wb_ack  <= resp_ack;
      o_wb_data <= resp_ack ? i_s_data[int'(owner)*DW +: DW] : '0;
      o_wb_err  <= any_err;
      if (any_err)
        o_wb_err_address <= unm_acc ? i_wb_addr : last_addr;
      if (accept)
        last_addr <= i_wb_addr;
      if (map_acc)
        owner <= dec_idx;
      // An error flushes every pending response; late acks then find nout == 0.
      if (!i_wb_cyc || any_err)
        nout <= '0;
      else
        nout <= nout + NW'(map_acc) - NW'(resp_ack);
      if (!i_wb_cyc || !busy || evt || tmo)
        timer <= '0;
      else
        timer <= timer + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_interconnect_nslave.sv
// Directed bench for wb_interconnect_nslave with a queued in-order slave responder.
module tb_wb_interconnect_nslave;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  addr = '0, wdata = '0;
  logic [3:0]   sel = 4'hF;
  logic         we = 1'b0, cyc = 1'b0, stb = 1'b0;
  logic         wb_ack, wb_stall, wb_err;
  logic [31:0]  wb_data, err_addr;
  logic [3:0]   s_cyc, s_stb;
  logic [31:0]  s_addr, s_wdata;
  logic [3:0]   s_sel;
  logic         s_we;
  logic [3:0]   s_ack, s_stall, s_err;
  logic [127:0] s_data;

  logic [3:0] hold = '0, err_mode = '0;
  logic       flush = 1'b0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  wb_interconnect_nslave #(
    .NS(4), .AW(32), .DW(32), .TIMEOUT(8), .MAXOUT(4)
  ) dut (
    .i_clk(clk), .i_reset(rst),
    .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel), .i_wb_we(we),
    .i_wb_cyc(cyc), .i_wb_stb(stb),
    .o_wb_ack(wb_ack), .o_wb_data(wb_data), .o_wb_stall(wb_stall),
    .o_wb_err(wb_err), .o_wb_err_address(err_addr),
    .o_s_cyc(s_cyc), .o_s_stb(s_stb), .o_s_addr(s_addr), .o_s_data(s_wdata),
    .o_s_sel(s_sel), .o_s_we(s_we),
    .i_s_ack(s_ack), .i_s_data(s_data), .i_s_stall(s_stall), .i_s_err(s_err)
  );

  // Read data is the request address XOR a per-slave salt (LED @0x8000_0000 -> 0x2A).
  function automatic logic [31:0] salt(input int k);
    case (k)
      0:       return 32'h1111_0000;
      1:       return 32'h8000_002A;
      2:       return 32'h8000_0000;
      default: return 32'h0000_0000;
    endcase
  endfunction

  typedef struct packed { logic [1:0] k; logic [31:0] a; } ent_t;
  ent_t q[$];

  initial s_stall = '0;

  // Slaves answer in order, one response per cycle, starting the cycle after the strobe.
  always @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      q.delete();
      s_ack  <= '0;
      s_err  <= '0;
      s_data <= '0;
    end else begin
      if ((|s_ack || |s_err) && q.size() != 0) void'(q.pop_front());
      for (int k = 0; k < 4; k++)
        if (s_stb[k] && !s_stall[k]) q.push_back({2'(k), s_addr});
      s_ack  <= '0;
      s_err  <= '0;
      s_data <= '0;
      if (q.size() != 0 && !hold[q[0].k]) begin
        if (err_mode[q[0].k]) s_err[q[0].k] <= 1'b1;
        else begin
          s_ack[q[0].k] <= 1'b1;
          s_data[int'(q[0].k)*32 +: 32] <= q[0].a ^ salt(int'(q[0].k));
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic read_ok(input logic [31:0] a, input logic [3:0] stb_exp,
                         input logic [31:0] d_exp, input string tag);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = a;
    #1;
    chk({tag, "_stall"}, 32'(wb_stall), 32'd0);
    chk({tag, "_sstb"},  32'(s_stb), 32'(stb_exp));
    tick;
    stb = 1'b0;
    chk({tag, "_ack_lat"}, 32'(wb_ack), 32'd0);
    tick;
    chk({tag, "_ack"},  32'(wb_ack), 32'd1);
    chk({tag, "_data"}, wb_data, d_exp);
    tick;
    chk({tag, "_ack_end"},  32'(wb_ack), 32'd0);
    chk({tag, "_data_end"}, wb_data, 32'd0);
  endtask

  logic [31:0] burst_d [4] = '{32'h1111_0100, 32'h1111_0104, 32'h1111_0108, 32'h1111_010C};

  initial begin
    // Reset state
    tick; tick;
    chk("rst_ack",  32'(wb_ack), 32'd0);
    chk("rst_err",  32'(wb_err), 32'd0);
    chk("rst_data", wb_data, 32'd0);
    chk("rst_eadr", err_addr, 32'd0);
    chk("rst_scyc", 32'(s_cyc), 32'd0);
    rst = 1'b0;
    tick;

    // Slave stall passes through while still strobing, then single LED read
    cyc = 1'b1; stb = 1'b1; addr = 32'h8000_0000; s_stall = 4'b0010;
    #1;
    chk("sstall_stall", 32'(wb_stall), 32'd1);
    chk("sstall_stb",   32'(s_stb), 32'h2);
    s_stall = '0;
    read_ok(32'h8000_0000, 4'b0010, 32'h0000_002A, "led");

    // Unmapped write
    stb = 1'b1; we = 1'b1; addr = 32'h9000_0000; wdata = 32'hDEAD_BEEF;
    #1;
    chk("unm_stall", 32'(wb_stall), 32'd0);
    chk("unm_sstb",  32'(s_stb), 32'd0);
    tick;
    stb = 1'b0; we = 1'b0;
    chk("unm_err",  32'(wb_err), 32'd1);
    chk("unm_eadr", err_addr, 32'h9000_0000);
    chk("unm_ack",  32'(wb_ack), 32'd0);
    tick;
    chk("unm_err_end", 32'(wb_err), 32'd0);

    // Burst of 4 SRAM reads held back, then a UART read blocked by MAXOUT/ownership
    hold[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      stb = 1'b1; addr = 32'h0000_0100 + 32'(i*4);
      #1;
      chk("burst_acc_stall", 32'(wb_stall), 32'd0);
      tick;
    end
    addr = 32'h8000_0008;
    #1;
    chk("burst_full_stall", 32'(wb_stall), 32'd1);
    chk("burst_full_sstb",  32'(s_stb), 32'd0);
    hold[0] = 1'b0;
    tick;
    chk("burst_first_ack", 32'(wb_ack), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("burst_stall_hold", 32'(wb_stall), 32'd1);
      tick;
      chk("burst_ack",  32'(wb_ack), 32'd1);
      chk("burst_data", wb_data, burst_d[i]);
    end
    chk("burst_stall_rel", 32'(wb_stall), 32'd0);
    chk("burst_uart_sstb", 32'(s_stb), 32'h4);
    tick;
    stb = 1'b0;
    chk("uart_ack_lat", 32'(wb_ack), 32'd0);
    tick;
    chk("uart_ack",  32'(wb_ack), 32'd1);
    chk("uart_data", wb_data, 32'h0000_0008);
    tick;

    // SRAM never answers: timeout after 8 idle cycles
    hold[0] = 1'b1;
    stb = 1'b1; addr = 32'h0000_0200;
    tick;
    stb = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      tick;
      chk($sformatf("tmo_err_%0d", j), 32'(wb_err), (j == 8) ? 32'd1 : 32'd0);
    end
    chk("tmo_eadr", err_addr, 32'h0000_0200);
    chk("tmo_ack",  32'(wb_ack), 32'd0);
    flush = 1'b1;
    tick;
    flush = 1'b0; hold[0] = 1'b0;
    chk("tmo_err_end", 32'(wb_err), 32'd0);
    read_ok(32'h8000_0000, 4'b0010, 32'h0000_002A, "led_after_tmo");

    // CDT slave reports an error
    err_mode[3] = 1'b1;
    stb = 1'b1; addr = 32'h8000_0010;
    tick;
    stb = 1'b0;
    tick;
    chk("serr_err",  32'(wb_err), 32'd1);
    chk("serr_ack",  32'(wb_ack), 32'd0);
    chk("serr_eadr", err_addr, 32'h8000_0010);
    tick;
    chk("serr_err_end", 32'(wb_err), 32'd0);
    err_mode[3] = 1'b0;

    // cyc dropped with 2 outstanding; late acks must be ignored
    hold[0] = 1'b1;
    stb = 1'b1; addr = 32'h0000_0300;
    tick;
    addr = 32'h0000_0304;
    tick;
    stb = 1'b0; cyc = 1'b0;
    #1;
    chk("drop_scyc", 32'(s_cyc), 32'd0);
    hold[0] = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tick;
      chk("drop_no_ack", 32'(wb_ack | wb_err), 32'd0);
    end
    read_ok(32'h8000_0000, 4'b0010, 32'h0000_002A, "led_after_drop");

    // Asynchronous reset between edges with two SRAM reads outstanding
    hold[0] = 1'b1;
    stb = 1'b1; addr = 32'h0000_0400;
    tick;
    addr = 32'h0000_0404;
    tick;
    stb = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_eadr", err_addr, 32'd0);
    chk("arst_ack",  32'(wb_ack), 32'd0);
    chk("arst_err",  32'(wb_err), 32'd0);
    chk("arst_data", wb_data, 32'd0);
    chk("arst_scyc", 32'(s_cyc), 32'd0);
    tick;
    rst = 1'b0; hold[0] = 1'b0;
    tick;
    read_ok(32'h8000_0000, 4'b0010, 32'h0000_002A, "led_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
